// File: rtl/gnr_node_param.sv
// Parallel gene-regulatory-network node: N_SIM independent copies of one boolean
// node with configurable function, update delay, change pulse and stability detection.
module gnr_node_param #(
  parameter int N_SIM    = 2,
  parameter int N_IN     = 3,
  parameter int DELAY_W  = 2,
  parameter int STABLE_N = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reset_nos,
  input  logic [N_SIM-1:0]             init_state,
  input  logic [N_SIM-1:0]             start,
  input  logic [DELAY_W-1:0]           delay,
  input  logic [1:0]                   mode,
  input  logic [$clog2(N_IN+1)-1:0]    threshold,
  input  logic [N_IN-1:0]              inh_mask,
  input  logic [N_SIM*N_IN-1:0]        reg_in,
  output logic [N_SIM-1:0]             s,
  output logic [N_SIM-1:0]             changed,
  output logic [N_SIM-1:0]             stable
);

  localparam int TH_W = $clog2(N_IN + 1);
  localparam int SC_W = $clog2(STABLE_N + 1);

  typedef enum logic [1:0] {
    MODE_OR   = 2'd0,
    MODE_AND  = 2'd1,
    MODE_THR  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  logic [N_SIM-1:0]   f;
  logic [DELAY_W-1:0] wait_q [N_SIM];
  logic [SC_W-1:0]    stab_q [N_SIM];

  // Candidate next state per copy; only committed when the copy actually updates.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    f = '0;
    for (int i = 0; i < N_SIM; i++) begin
      logic [N_IN-1:0] x;
      logic [TH_W-1:0] ones;
      x    = reg_in[i*N_IN +: N_IN] ^ inh_mask;
      ones = '0;
      for (int j = 0; j < N_IN; j++) begin
        ones = ones + TH_W'(x[j]);
      end
      case (mode_e'(mode))
        MODE_OR:   f[i] = |x;
        MODE_AND:  f[i] = &x;
        MODE_THR:  f[i] = (ones >= threshold);
        MODE_HOLD: f[i] = s[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every copy sees pre-edge values.
    if (!rst) begin
      s       <= '0;
      changed <= '0;
      for (int i = 0; i < N_SIM; i++) begin
        wait_q[i] <= '0;
        stab_q[i] <= '0;
      end
    end else if (reset_nos) begin
      s       <= init_state;
      changed <= '0;
      for (int i = 0; i < N_SIM; i++) begin
        wait_q[i] <= '0;
        stab_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SIM; i++) begin
        changed[i] <= 1'b0;
        if (start[i]) begin
          if (wait_q[i] == '0) begin
            s[i]       <= f[i];
            wait_q[i]  <= delay;
            changed[i] <= f[i] ^ s[i];
            if (f[i] != s[i]) begin
              stab_q[i] <= '0;
            end else if (stab_q[i] != SC_W'(STABLE_N)) begin
              stab_q[i] <= stab_q[i] + SC_W'(1);
            end
          end else begin
            // Skipped strobe: only the delay countdown moves.
            wait_q[i] <= wait_q[i] - DELAY_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    stable = '0;
    for (int i = 0; i < N_SIM; i++) begin
      stable[i] = (stab_q[i] == SC_W'(STABLE_N));
    end
  end

endmodule

// File: tb/tb_gnr_node_param.sv
// Bench for gnr_node_param: directed scenarios plus random traffic, compared every
// cycle against an arithmetic reference model; a second N_IN=4 instance covers threshold > N_IN.
module tb_gnr_node_param;

  localparam int N_SIM    = 2;
  localparam int N_IN     = 3;
  localparam int DELAY_W  = 2;
  localparam int STABLE_N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              reset_nos = 1'b0;
  logic [1:0]        init_state = '0;
  logic [1:0]        start = '0;
  logic [1:0]        delay = '0;
  logic [1:0]        mode = '0;
  logic [1:0]        threshold = '0;
  logic [2:0]        inh_mask = '0;
  logic [5:0]        reg_in = '0;
  logic [1:0]        s, changed, stable;

  logic [2:0]        th2 = '0;
  logic [3:0]        mask2 = '0;
  logic [7:0]        reg_in2 = '0;
  logic [1:0]        s2, changed2, stable2;

  int vectors = 0;
  int miscompares = 0;

  int m_s [N_SIM];
  int m_wait [N_SIM];
  int m_cnt [N_SIM];
  int m_chg [N_SIM];

  always #5 clk = ~clk;

  gnr_node_param #(.N_SIM(N_SIM), .N_IN(N_IN), .DELAY_W(DELAY_W), .STABLE_N(STABLE_N)) u_dut (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state), .start(start),
    .delay(delay), .mode(mode), .threshold(threshold), .inh_mask(inh_mask), .reg_in(reg_in),
    .s(s), .changed(changed), .stable(stable)
  );

  gnr_node_param #(.N_SIM(2), .N_IN(4), .DELAY_W(2), .STABLE_N(4)) u_dut4 (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state), .start(start),
    .delay(delay), .mode(mode), .threshold(th2), .inh_mask(mask2), .reg_in(reg_in2),
    .s(s2), .changed(changed2), .stable(stable2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge, from the current input values.
  task automatic model_step();
    for (int i = 0; i < N_SIM; i++) begin
      if (!rst) begin
        m_s[i] = 0; m_wait[i] = 0; m_cnt[i] = 0; m_chg[i] = 0;
      end else if (reset_nos) begin
        m_s[i] = int'(init_state[i]); m_wait[i] = 0; m_cnt[i] = 0; m_chg[i] = 0;
      end else begin
        m_chg[i] = 0;
        if (start[i]) begin
          if (m_wait[i] == 0) begin
            logic [2:0] x;
            int ones, nf;
            x    = reg_in[i*N_IN +: N_IN] ^ inh_mask;
            ones = $countones(x);
            case (mode)
              2'd0:    nf = (ones > 0) ? 1 : 0;
              2'd1:    nf = (ones == N_IN) ? 1 : 0;
              2'd2:    nf = (ones >= int'(threshold)) ? 1 : 0;
              default: nf = m_s[i];
            endcase
            if (nf != m_s[i]) begin
              m_chg[i] = 1;
              m_cnt[i] = 0;
            end else begin
              m_cnt[i] = (m_cnt[i] + 1 > STABLE_N) ? STABLE_N : m_cnt[i] + 1;
            end
            m_s[i]    = nf;
            m_wait[i] = int'(delay);
          end else begin
            m_wait[i] = m_wait[i] - 1;
          end
        end
      end
    end
  endtask

  // Advance one clock and compare every output against the model, #1 after the edge.
  task automatic cyc(input string tag);
    logic [1:0] es, ec, est;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_SIM; i++) begin
      es[i]  = m_s[i][0];
      ec[i]  = m_chg[i][0];
      est[i] = (m_cnt[i] == STABLE_N);
    end
    check({tag, "_s"}, 32'(s), 32'(es));
    check({tag, "_changed"}, 32'(changed), 32'(ec));
    check({tag, "_stable"}, 32'(stable), 32'(est));
  endtask

  initial begin
    logic [5:0] pat22 [5];
    logic [1:0] exp22 [5];
    pat22[0] = 6'b000_010; pat22[1] = 6'b000_000; pat22[2] = 6'b000_000;
    pat22[3] = 6'b000_010; pat22[4] = 6'b000_010;
    exp22[0] = 2'd1; exp22[1] = 2'd1; exp22[2] = 2'd0; exp22[3] = 2'd0; exp22[4] = 2'd1;

    // Power-on reset
    cyc("rst0");
    cyc("rst1");
    check("reset_s", 32'(s), 32'h0);
    check("reset_stable", 32'(stable), 32'h0);
    rst = 1'b1;

    // Single update in OR mode produces a one-cycle change pulse
    mode = 2'd0; inh_mask = '0; delay = '0; reg_in = 6'b000_010; start = 2'b01;
    cyc("or_upd");
    check("or_s0", 32'(s[0]), 32'h1);
    check("or_chg0", 32'(changed[0]), 32'h1);
    start = 2'b00;
    cyc("or_idle");
    check("or_chg0_drop", 32'(changed[0]), 32'h0);

    // delay=1 after reset_nos: strobes 1,3,5 update, 2,4 are skipped
    delay = 2'd1; reset_nos = 1'b1; init_state = 2'b00;
    cyc("nos22");
    reset_nos = 1'b0; start = 2'b01;
    for (int k = 0; k < 5; k++) begin
      reg_in = pat22[k];
      cyc("dly1");
      check($sformatf("dly1_s0_strobe%0d", k + 1), 32'(s[0]), 32'(exp22[k]));
    end
    start = 2'b00;

    // Threshold mode with an inhibitory input
    delay = '0; mode = 2'd2; threshold = 2'd2; inh_mask = 3'b001;
    reg_in = 6'b001_000; start = 2'b10;
    cyc("thr_lo");
    check("thr_s1_lo", 32'(s[1]), 32'h0);
    reg_in = 6'b110_000;
    cyc("thr_hi");
    check("thr_s1_hi", 32'(s[1]), 32'h1);

    // Stability after STABLE_N unchanged updates, then broken by a change
    reset_nos = 1'b1; init_state = 2'b00; start = 2'b00;
    cyc("nos24");
    reset_nos = 1'b0; mode = 2'd0; inh_mask = '0; reg_in = '0; start = 2'b11;
    for (int k = 0; k < STABLE_N; k++) begin
      cyc("stab_run");
      if (k == STABLE_N - 2) check("stab_not_yet", 32'(stable), 32'h0);
    end
    check("stab_reached", 32'(stable), 32'h3);
    reg_in = 6'b000_111; start = 2'b01;
    cyc("stab_break");
    check("stab_break_st", 32'(stable), 32'h2);
    check("stab_break_chg", 32'(changed), 32'h1);

    // reset_nos wins over start; rst mid-delay clears any pending wait
    delay = 2'd2; reg_in = 6'b111_111; reset_nos = 1'b1; start = 2'b11; init_state = 2'b10;
    cyc("nos_vs_start");
    check("nos_prio_s", 32'(s), 32'h2);
    check("nos_prio_chg", 32'(changed), 32'h0);
    reset_nos = 1'b0; start = 2'b01;
    cyc("mid_upd");
    cyc("mid_skip");
    rst = 1'b0;
    cyc("mid_rst");
    check("mid_rst_s", 32'(s), 32'h0);
    check("mid_rst_chg", 32'(changed), 32'h0);
    rst = 1'b1;
    cyc("post_rst");
    check("post_rst_s0", 32'(s[0]), 32'h1);

    // Threshold boundaries: 0 always true, N_IN+1 always false (N_IN=4 instance)
    reset_nos = 1'b1; init_state = 2'b00; start = 2'b00;
    cyc("nos26");
    reset_nos = 1'b0; delay = '0; mode = 2'd2; start = 2'b11;
    threshold = 2'd0; th2 = 3'd0;
    for (int p = 0; p < 16; p++) begin
      reg_in  = {p[2:0], p[2:0]};
      reg_in2 = {p[3:0], p[3:0]};
      inh_mask = 3'($urandom);
      mask2    = 4'($urandom);
      cyc("th0");
      check("th0_s4", 32'(s2), 32'h3);
    end
    threshold = 2'd3; th2 = 3'd5;
    for (int p = 0; p < 16; p++) begin
      reg_in  = {p[2:0], p[2:0]};
      reg_in2 = {p[3:0], p[3:0]};
      inh_mask = 3'($urandom);
      mask2    = 4'($urandom);
      cyc("thmax");
      check("thmax_s4", 32'(s2), 32'h0);
    end

    // Random traffic against the model
    for (int k = 0; k < 500; k++) begin
      rst        = ($urandom_range(0, 39) != 0);
      reset_nos  = ($urandom_range(0, 19) == 0);
      init_state = 2'($urandom);
      start      = 2'($urandom) | 2'($urandom);
      delay      = 2'($urandom);
      mode       = 2'($urandom);
      threshold  = 2'($urandom);
      inh_mask   = 3'($urandom);
      reg_in     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : reg_in;
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
